mem_store_buffer: RTL and testbench

Parametrised store path between the execute stage and the dmem/imem write ports. Each store is byte-lane aligned and masked, region-decoded and queued in a DEPTH-entry FIFO. The FIFO drains one entry per cycle when memory accepts it. Flags misaligned/illegal stores and raises a hazard to loads that target a word still pending in the buffer.

---
 rtl/mem_store_buffer_if.sv | 38 +++
 rtl/mem_store_buffer.sv | 147 ++++++++++++++
 tb/tb_mem_store_buffer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_buffer_if.sv
// Store-buffer bus: execute-stage store/load request side plus the memory write side.
// The slave modport is the buffer's view of the bus; the master modport is its environment's view.
interface mem_store_buffer_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 4
);
    localparam int NBYTES = DWIDTH / 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [AWIDTH-1:0] st_addr;
    logic [DWIDTH-1:0] st_data;
    logic [1:0]        st_size;
    logic              st_err;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [NBYTES-1:0] dmem_we;
    logic [NBYTES-1:0] imem_we;
    logic              mem_ready;
    logic [AWIDTH-1:0] ld_addr;
    logic              ld_hazard;
    logic [CW-1:0]     count;
    logic              empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ready, ld_addr,
        output st_ready, st_err, mem_addr, mem_wdata, dmem_we, imem_we,
               ld_hazard, count, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ready, ld_addr,
        input  st_ready, st_err, mem_addr, mem_wdata, dmem_we, imem_we,
               ld_hazard, count, empty
    );
endinterface

// File: rtl/mem_store_buffer.sv
// Byte-lane aligning store buffer with region decode, FIFO drain to dmem/imem and load hazard detect.
// Optional macro STBUF_COALESCE_EN merges a store into the youngest entry when it hits the same word and target.
module mem_store_buffer #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               rst,
    mem_store_buffer_if.slave bus
);
    localparam int NBYTES = DWIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam int WAW    = AWIDTH - OFFW;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;

    logic [WAW-1:0]    addr_q [DEPTH];
    logic [NBYTES-1:0] mask_q [DEPTH];
    logic [DWIDTH-1:0] data_q [DEPTH];
    logic [1:0]        tgt_q  [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              st_err_q, st_err_d;

    logic [OFFW-1:0]   off;
    logic [WAW-1:0]    waddr_new;
    logic [3:0]        region;
    logic [1:0]        tgt_new;
    logic [NBYTES-1:0] mask_new;
    logic [DWIDTH-1:0] data_new;
    logic              illegal, misaligned;
    logic              full, empty_w, accept, pop, enq, merge, push;
    logic              hazard;

    always_comb begin
        off        = bus.st_addr[OFFW-1:0];
        waddr_new  = bus.st_addr[AWIDTH-1:OFFW];
        region     = bus.st_addr[AWIDTH-1:AWIDTH-4];
        illegal    = (32'd1 << bus.st_size) > 32'(NBYTES);
        misaligned = |(off & OFFW'((32'd1 << bus.st_size) - 32'd1));
        data_new   = bus.st_data << {off, 3'b000};
        mask_new   = '0;
        for (int b = 0; b < NBYTES; b++) begin
            mask_new[b] = (b >= int'(off)) && (b < int'(off) + (1 << bus.st_size));
        end
        case (region)
            4'b0001: tgt_new = 2'b01;
            4'b0010: tgt_new = 2'b10;
            4'b0011: tgt_new = 2'b11;
            default: tgt_new = 2'b00;
        endcase
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign accept  = bus.st_valid && !full;
    assign pop     = bus.mem_ready && !empty_w;
    // Unmapped regions are swallowed silently: accepted but never queued.
    assign enq     = accept && !illegal && !misaligned && (tgt_new != 2'b00);

`ifdef STBUF_COALESCE_EN
    logic [PW-1:0]     tail;
    logic [DWIDTH-1:0] lane_new;

    assign tail  = wr_ptr_q - PW'(1);
    // A lone entry that is leaving this cycle cannot absorb the store.
    assign merge = enq && !empty_w && !(pop && count_q == CW'(1))
                   && (addr_q[tail] == waddr_new) && (tgt_q[tail] == tgt_new);

    always_comb begin
        lane_new = '0;
        for (int b = 0; b < NBYTES; b++) begin
            lane_new[8*b +: 8] = {8{mask_new[b]}};
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign push = enq && !merge;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        st_err_d = accept && (illegal || misaligned);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
                data_q[i] <= '0;
                tgt_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_err_q <= st_err_d;
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                addr_q[wr_ptr_q] <= waddr_new;
                mask_q[wr_ptr_q] <= mask_new;
                data_q[wr_ptr_q] <= data_new;
                tgt_q[wr_ptr_q]  <= tgt_new;
                vld_q[wr_ptr_q]  <= 1'b1;
            end
`ifdef STBUF_COALESCE_EN
            if (merge) begin
                mask_q[tail] <= mask_q[tail] | mask_new;
                data_q[tail] <= (data_q[tail] & ~lane_new) | (data_new & lane_new);
            end
`endif
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == bus.ld_addr[AWIDTH-1:OFFW])) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.st_ready  = !full;
    assign bus.st_err    = st_err_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_w;
    assign bus.ld_hazard = hazard;
    assign bus.mem_addr  = empty_w ? '0 : {addr_q[rd_ptr_q], {OFFW{1'b0}}};
    assign bus.mem_wdata = empty_w ? '0 : data_q[rd_ptr_q];
    assign bus.dmem_we   = (!empty_w && tgt_q[rd_ptr_q][0]) ? mask_q[rd_ptr_q] : '0;
    assign bus.imem_we   = (!empty_w && tgt_q[rd_ptr_q][1]) ? mask_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the store buffer.
module tb_mem_store_buffer;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef STBUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct {
        logic [29:0] waddr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [1:0]  tgt;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_store_buffer_if #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) sb_if ();

    mem_store_buffer #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb_if.slave)
    );

    ent_t mq[$];
    bit   exp_err;
    int   checks = 0;
    int   failures = 0;

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        ent_t e, t;
        bit rdy, acc, bad, pop, mrg;
        int off, sz, rg;
        rdy = mq.size() < DEPTH;
        acc = sb_if.st_valid && rdy;
        off = int'(sb_if.st_addr % 4);
        sz  = 1 << sb_if.st_size;
        bad = (sz > 4) || ((off % sz) != 0);
        rg  = int'(sb_if.st_addr >> 28);
        e.tgt   = (rg == 1) ? 2'b01 : (rg == 2) ? 2'b10 : (rg == 3) ? 2'b11 : 2'b00;
        e.waddr = 30'(sb_if.st_addr >> 2);
        e.mask  = 4'(((1 << sz) - 1) << off);
        e.data  = 32'(64'(sb_if.st_data) << (8 * off));
        pop = sb_if.mem_ready && (mq.size() > 0);
        mrg = 1'b0;
        if (COAL && acc && !bad && e.tgt != 2'b00 && mq.size() > 0 && !(pop && mq.size() == 1)) begin
            t = mq[mq.size()-1];
            mrg = (t.waddr == e.waddr) && (t.tgt == e.tgt);
        end
        if (pop) void'(mq.pop_front());
        if (acc && !bad && e.tgt != 2'b00) begin
            if (mrg) begin
                t = mq[mq.size()-1];
                for (int b = 0; b < 4; b++) if (e.mask[b]) t.data[8*b +: 8] = e.data[8*b +: 8];
                t.mask = t.mask | e.mask;
                mq[mq.size()-1] = t;
            end else begin
                mq.push_back(e);
            end
        end
        exp_err = acc && bad;
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        sb_if.st_valid = v;
        sb_if.st_addr  = a;
        sb_if.st_data  = d;
        sb_if.st_size  = s;
    endtask

    task automatic drain();
        sb_if.st_valid  = 1'b0;
        sb_if.mem_ready = 1'b1;
        repeat (DEPTH + 2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_st(1'b0, 32'h0, 32'h0, 2'd0);
        sb_if.mem_ready = 1'b0;
        sb_if.ld_addr   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        exp_err = 1'b0;
        checks++; if (sb_if.count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", sb_if.count); end
        checks++; if (sb_if.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", sb_if.empty); end
        checks++; if (sb_if.st_err !== 1'b0) begin failures++; $display("FAIL reset_st_err got=%b exp=0", sb_if.st_err); end
        checks++; if (sb_if.dmem_we !== 4'b0 || sb_if.imem_we !== 4'b0) begin failures++; $display("FAIL reset_we got=%b/%b exp=0000/0000", sb_if.dmem_we, sb_if.imem_we); end
        checks++; if (sb_if.mem_addr !== 32'h0 || sb_if.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem got=%h/%h exp=0/0", sb_if.mem_addr, sb_if.mem_wdata); end
        checks++; if (sb_if.st_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sb_if.st_ready); end
        rst = 1'b0;
    endtask

    task automatic test_dmem_byte();
        set_st(1'b1, 32'h1000_0003, 32'h0000_00AB, 2'd0);
        sb_if.mem_ready = 1'b1;
        tick();
        sb_if.st_valid = 1'b0;
        checks++; if (sb_if.dmem_we !== 4'b1000) begin failures++; $display("FAIL sb_dmem_we got=%b exp=1000", sb_if.dmem_we); end
        checks++; if (sb_if.imem_we !== 4'b0000) begin failures++; $display("FAIL sb_imem_we got=%b exp=0000", sb_if.imem_we); end
        checks++; if (sb_if.mem_wdata !== 32'hAB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=ab000000", sb_if.mem_wdata); end
        checks++; if (sb_if.mem_addr !== 32'h1000_0000) begin failures++; $display("FAIL sb_addr got=%h exp=10000000", sb_if.mem_addr); end
        tick();
        checks++; if (sb_if.empty !== 1'b1 || sb_if.dmem_we !== 4'b0) begin failures++; $display("FAIL sb_popped empty=%b we=%b exp=1/0000", sb_if.empty, sb_if.dmem_we); end
    endtask

    task automatic test_both_half();
        set_st(1'b1, 32'h3000_0002, 32'h0000_1234, 2'd1);
        sb_if.mem_ready = 1'b0;
        tick();
        sb_if.st_valid = 1'b0;
        checks++; if (sb_if.dmem_we !== 4'b1100 || sb_if.imem_we !== 4'b1100) begin failures++; $display("FAIL sh_both_we got=%b/%b exp=1100/1100", sb_if.dmem_we, sb_if.imem_we); end
        checks++; if (sb_if.mem_wdata !== 32'h1234_0000) begin failures++; $display("FAIL sh_both_wdata got=%h exp=12340000", sb_if.mem_wdata); end
        drain();
    endtask

    task automatic test_errors();
        logic [31:0] ea [4] = '{32'h1000_0002, 32'h1000_0001, 32'h1000_0000, 32'h5000_0000};
        logic [1:0]  es [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        bit          ee [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        sb_if.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, ea[i], 32'hDEAD_BEEF, es[i]);
            tick();
            sb_if.st_valid = 1'b0;
            checks++; if (sb_if.st_err !== ee[i]) begin failures++; $display("FAIL err_pulse case=%0d got=%b exp=%b", i, sb_if.st_err, ee[i]); end
            checks++; if (sb_if.count !== '0) begin failures++; $display("FAIL err_count case=%0d got=%0d exp=0", i, sb_if.count); end
            tick();
            checks++; if (sb_if.st_err !== 1'b0) begin failures++; $display("FAIL err_clear case=%0d got=%b exp=0", i, sb_if.st_err); end
        end
    endtask

    task automatic test_full_drain();
        logic [31:0] d [4];
        sb_if.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            set_st(1'b1, 32'h1000_0100 + 32'(4 * i), d[i], 2'd2);
            tick();
        end
        checks++; if (sb_if.count !== CW'(4)) begin failures++; $display("FAIL full_count got=%0d exp=4", sb_if.count); end
        checks++; if (sb_if.st_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", sb_if.st_ready); end
        set_st(1'b1, 32'h1000_0200, 32'h5555_5555, 2'd2);
        tick();
        checks++; if (sb_if.count !== CW'(4)) begin failures++; $display("FAIL full_hold got=%0d exp=4", sb_if.count); end
        sb_if.mem_ready = 1'b1;
        #1;
        checks++; if (sb_if.st_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%b exp=0", sb_if.st_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (sb_if.mem_addr !== 32'h1000_0100 + 32'(4 * i) || sb_if.mem_wdata !== d[i]) begin
                failures++; $display("FAIL drain_order i=%0d got=%h/%h exp=%h/%h", i, sb_if.mem_addr, sb_if.mem_wdata, 32'h1000_0100 + 32'(4 * i), d[i]);
            end
            tick();
            sb_if.st_valid = 1'b0;
        end
        checks++; if (sb_if.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", sb_if.empty); end
    endtask

    task automatic test_hazard();
        sb_if.mem_ready = 1'b0;
        set_st(1'b1, 32'h1000_0010, 32'h0BAD_F00D, 2'd2);
        tick();
        sb_if.st_valid = 1'b0;
        sb_if.ld_addr = 32'h1000_0013; #1;
        checks++; if (sb_if.ld_hazard !== 1'b1) begin failures++; $display("FAIL hz_match got=%b exp=1", sb_if.ld_hazard); end
        sb_if.ld_addr = 32'h1000_0014; #1;
        checks++; if (sb_if.ld_hazard !== 1'b0) begin failures++; $display("FAIL hz_nomatch got=%b exp=0", sb_if.ld_hazard); end
        sb_if.ld_addr = 32'h1000_0010;
        sb_if.mem_ready = 1'b1; #1;
        checks++; if (sb_if.ld_hazard !== 1'b1) begin failures++; $display("FAIL hz_popping got=%b exp=1", sb_if.ld_hazard); end
        tick();
        checks++; if (sb_if.ld_hazard !== 1'b0) begin failures++; $display("FAIL hz_drained got=%b exp=0", sb_if.ld_hazard); end
    endtask

    task automatic test_coalesce();
        sb_if.mem_ready = 1'b0;
        set_st(1'b1, 32'h1000_0000, 32'h0000_0011, 2'd0);
        tick();
        set_st(1'b1, 32'h1000_0001, 32'h0000_0022, 2'd0);
        tick();
        sb_if.st_valid = 1'b0;
        if (COAL) begin
            checks++; if (sb_if.count !== CW'(1) || sb_if.dmem_we !== 4'b0011 || sb_if.mem_wdata !== 32'h0000_2211) begin
                failures++; $display("FAIL coalesce got=%0d/%b/%h exp=1/0011/00002211", sb_if.count, sb_if.dmem_we, sb_if.mem_wdata);
            end
        end else begin
            checks++; if (sb_if.count !== CW'(2) || sb_if.dmem_we !== 4'b0001 || sb_if.mem_wdata !== 32'h0000_0011) begin
                failures++; $display("FAIL no_coalesce got=%0d/%b/%h exp=2/0001/00000011", sb_if.count, sb_if.dmem_we, sb_if.mem_wdata);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_drain();
        sb_if.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_st(1'b1, 32'h2000_0040 + 32'(4 * i), $urandom, 2'd2);
            tick();
        end
        sb_if.st_valid  = 1'b0;
        sb_if.mem_ready = 1'b1;
        rst = 1'b1; #1;
        mq.delete();
        exp_err = 1'b0;
        checks++; if (sb_if.count !== '0 || sb_if.imem_we !== 4'b0) begin failures++; $display("FAIL rst_mid got=%0d/%b exp=0/0000", sb_if.count, sb_if.imem_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            tick();
            checks++; if (sb_if.imem_we !== 4'b0 || sb_if.dmem_we !== 4'b0) begin failures++; $display("FAIL rst_mid_write got=%b/%b exp=0000/0000", sb_if.dmem_we, sb_if.imem_we); end
        end
    endtask

    task automatic test_random();
        int rgs [4] = '{1, 2, 3, 5};
        ent_t h;
        bit hz;
        logic [31:0] ea, ed;
        logic [3:0]  edwe, eiwe;
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_st(($urandom_range(0, 9) < 7), (32'(rgs[$urandom_range(0, 3)]) << 28) | 32'($urandom_range(0, 23)),
                   $urandom, 2'($urandom_range(0, 3)));
            sb_if.mem_ready = ($urandom_range(0, 9) < 4);
            sb_if.ld_addr   = (32'(rgs[$urandom_range(0, 2)]) << 28) | 32'($urandom_range(0, 23));
            #1;
            hz = 1'b0;
            foreach (mq[k]) if (mq[k].waddr == 30'(sb_if.ld_addr >> 2)) hz = 1'b1;
            checks++; if (sb_if.ld_hazard !== hz) begin failures++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", cyc, sb_if.ld_hazard, hz); end
            checks++; if (sb_if.st_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, sb_if.st_ready, mq.size() < DEPTH); end
            tick();
            ea = 32'h0; ed = 32'h0; edwe = 4'h0; eiwe = 4'h0;
            if (mq.size() > 0) begin
                h = mq[0];
                ea = {h.waddr, 2'b00};
                ed = h.data;
                edwe = h.tgt[0] ? h.mask : 4'h0;
                eiwe = h.tgt[1] ? h.mask : 4'h0;
            end
            checks++; if (sb_if.count !== CW'(mq.size()) || sb_if.empty !== (mq.size() == 0)) begin
                failures++; $display("FAIL rnd_count cyc=%0d got=%0d/%b exp=%0d/%b", cyc, sb_if.count, sb_if.empty, mq.size(), mq.size() == 0);
            end
            checks++; if (sb_if.mem_addr !== ea || sb_if.mem_wdata !== ed) begin
                failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", cyc, sb_if.mem_addr, sb_if.mem_wdata, ea, ed);
            end
            checks++; if (sb_if.dmem_we !== edwe || sb_if.imem_we !== eiwe) begin
                failures++; $display("FAIL rnd_we cyc=%0d got=%b/%b exp=%b/%b", cyc, sb_if.dmem_we, sb_if.imem_we, edwe, eiwe);
            end
            checks++; if (sb_if.st_err !== exp_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, sb_if.st_err, exp_err); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_dmem_byte();
        test_both_half();
        test_errors();
        test_full_drain();
        test_hazard();
        test_coalesce();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
